// File: rtl/sigma_delta_mc_dac.sv
// sigma_delta_mc_dac: multi-channel 1-bit sigma-delta DAC.
//
// Each channel runs a 1st- or 2nd-order modulator (ORDER) with saturating
// integrators (INT_W bits). Samples are written into a per-channel pending
// register and moved to the active registers of all channels at once on
// sample_rate_trig. The modulators update on a tick, which fires once every
// OSR_DIV clocks.
//
// Optional feature macro: SIGMA_DELTA_DITHER_EN
//   When defined, each channel gets a 16-bit Galois LFSR. Its top 4 bits,
//   scaled by 2^(DATA_W-10), are added to the quantizer input only.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   sample_in         signed Q2.(DATA_W-2) sample
//   sample_in_ch      target channel for sample_in
//   sample_in_rdy     strobe: sample_in -> pending[sample_in_ch]
//   sample_rate_trig  strobe: pending -> active, all channels
//   sat_clr           clears all sticky saturation flags
//   dout              1-bit modulator output per channel
//   sat_flag          sticky per-channel clamp/saturation flag

// Per-channel modulator.
module sigma_delta_ch #(
  parameter int DATA_W = 18,
  parameter int ORDER  = 2,
  parameter int INT_W  = 24
`ifdef SIGMA_DELTA_DITHER_EN
  ,
  parameter int CH_IDX = 0
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              sat_clr,
  input  logic [DATA_W-1:0] active,
  output logic              dout,
  output logic              sat_flag
);
  // One guard bit beyond INT_W+1: the 2nd stage adds three full-range terms.
  localparam int SW = INT_W + 2;
  localparam logic signed [INT_W-1:0] FS_P  = INT_W'(1 << (DATA_W-2));
  localparam logic signed [INT_W-1:0] FS_N  = -FS_P;
  localparam logic signed [INT_W-1:0] I_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] I_MIN = {1'b1, {(INT_W-1){1'b0}}};

  function automatic logic signed [SW-1:0] sx(input logic signed [INT_W-1:0] v);
    return {{2{v[INT_W-1]}}, v};
  endfunction

  // Returns {clipped, value}.
  function automatic logic [INT_W:0] sat(input logic signed [SW-1:0] s);
    if (s > sx(I_MAX))      return {1'b1, I_MAX};
    else if (s < sx(I_MIN)) return {1'b1, I_MIN};
    else                    return {1'b0, s[INT_W-1:0]};
  endfunction

  logic signed [INT_W-1:0] a_ext, x, fb, i1, i1n, q;
  logic signed [SW-1:0]    s1;
  logic                    clamp, sat1, sat2, q_ge;

  always_comb begin
    a_ext = {{(INT_W-DATA_W){active[DATA_W-1]}}, active};
    clamp = 1'b0;
    x     = a_ext;
    if (a_ext > FS_P) begin
      x     = FS_P;
      clamp = 1'b1;
    end else if (a_ext < FS_N) begin
      x     = FS_N;
      clamp = 1'b1;
    end
    fb = dout ? FS_P : FS_N;
    s1 = sx(i1) + sx(x) - sx(fb);
    {sat1, i1n} = sat(s1);
  end

  generate
    if (ORDER == 2) begin : g_o2
      logic signed [INT_W-1:0] i2, i2n;
      logic signed [SW-1:0]    s2;
      always_comb begin
        s2 = sx(i2) + sx(i1n) - sx(fb);
        {sat2, i2n} = sat(s2);
        q = i2n;
      end
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  i2 <= '0;
        else if (tick) i2 <= i2n;
      end
    end else begin : g_o1
      assign q    = i1n;
      assign sat2 = 1'b0;
    end
  endgenerate

`ifdef SIGMA_DELTA_DITHER_EN
  logic [15:0]             lfsr;
  logic signed [INT_W-1:0] dith;
  logic signed [SW-1:0]    qd;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  lfsr <= 16'hACE1 ^ 16'(CH_IDX);
    else if (tick) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Dither only perturbs the compare; integrators never see it.
  always_comb begin
    dith = {{(INT_W-4){lfsr[15]}}, lfsr[15:12]};
    dith = dith <<< (DATA_W-10);
    qd   = sx(q) + sx(dith);
    q_ge = ~qd[SW-1];
  end
`else
  assign q_ge = ~q[INT_W-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1       <= '0;
      dout     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (tick) begin
        i1   <= i1n;
        dout <= q_ge;
      end
      // A set event on this tick beats a simultaneous clear.
      if (tick && (clamp || sat1 || sat2)) sat_flag <= 1'b1;
      else if (sat_clr)                    sat_flag <= 1'b0;
    end
  end
endmodule

module sigma_delta_mc_dac #(
  parameter  int NUM_CH  = 2,
  parameter  int DATA_W  = 18,
  parameter  int ORDER   = 2,
  parameter  int INT_W   = 24,
  parameter  int OSR_DIV = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [CH_W-1:0]   sample_in_ch,
  input  logic              sample_in_rdy,
  input  logic              sample_rate_trig,
  input  logic              sat_clr,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] sat_flag
);
  generate
    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("sigma_delta_mc_dac: ORDER must be 1 or 2");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_nch
      $error("sigma_delta_mc_dac: NUM_CH must be 1..8");
    end
    if (INT_W < DATA_W + 3) begin : g_bad_intw
      $error("sigma_delta_mc_dac: INT_W must be >= DATA_W+3");
    end
    if (OSR_DIV < 1) begin : g_bad_osr
      $error("sigma_delta_mc_dac: OSR_DIV must be >= 1");
    end
`ifdef SIGMA_DELTA_DITHER_EN
    if (DATA_W < 10) begin : g_bad_dith
      $error("sigma_delta_mc_dac: dither needs DATA_W >= 10");
    end
`endif
  endgenerate

  logic [NUM_CH-1:0][DATA_W-1:0] pending, active;
  logic [CNT_W-1:0]              cnt;
  logic                          tick;

  // Out-of-range channel indices match no c and are dropped. A write in the
  // trigger cycle commits straight through to active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      active  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sample_in_rdy && sample_in_ch == CH_W'(c)) pending[c] <= sample_in;
        if (sample_rate_trig)
          active[c] <= (sample_in_rdy && sample_in_ch == CH_W'(c)) ? sample_in : pending[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          cnt <= '0;
    else if (cnt == CNT_W'(OSR_DIV - 1))   cnt <= '0;
    else                                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == '0);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sigma_delta_ch #(
        .DATA_W (DATA_W),
        .ORDER  (ORDER),
        .INT_W  (INT_W)
`ifdef SIGMA_DELTA_DITHER_EN
        ,
        .CH_IDX (c)
`endif
      ) u_ch (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .sat_clr  (sat_clr),
        .active   (active[c]),
        .dout     (dout[c]),
        .sat_flag (sat_flag[c])
      );
    end
  endgenerate
endmodule

// File: tb/tb_sigma_delta_mc_dac.sv
// Directed bench for sigma_delta_mc_dac. dut: 2 channels, tick every clock.
// dut4: 3 channels, tick every 4th clock, used for tick alignment, illegal
// channel index and clear-then-reset of sat_flag between ticks.
module tb_sigma_delta_mc_dac;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [17:0] sample_in;
  logic        ch, rdy, trig, sat_clr;
  logic [1:0]  ch4;
  logic        rdy4;
  logic [1:0]  dout, sat_flag;
  logic [2:0]  dout4, sat_flag4;

  int checks = 0, errors = 0;
  int ec;
  bit mon = 1'b0;
  int changes = 0, bad = 0;
  logic [2:0] prev4;

  always #5 clk = ~clk;

  // Posedges since reset release; at a negedge, the edge just taken is ec-1.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ec <= 0;
    else          ec <= ec + 1;

  sigma_delta_mc_dac #(.NUM_CH(2), .DATA_W(18), .ORDER(2), .INT_W(24), .OSR_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_in_ch(ch),
    .sample_in_rdy(rdy), .sample_rate_trig(trig), .sat_clr(sat_clr),
    .dout(dout), .sat_flag(sat_flag));

  sigma_delta_mc_dac #(.NUM_CH(3), .DATA_W(18), .ORDER(2), .INT_W(24), .OSR_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_in_ch(ch4),
    .sample_in_rdy(rdy4), .sample_rate_trig(trig), .sat_clr(sat_clr),
    .dout(dout4), .sat_flag(sat_flag4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge; optionally watch dut4 output changes.
  task automatic cyc();
    @(negedge clk);
    if (mon) begin
      if (dout4 !== prev4) begin
        changes++;
        if (((ec - 1) % 4) != 0) bad++;
      end
      prev4 = dout4;
    end
  endtask

  task automatic put(input logic c, input logic [1:0] c4, input logic [17:0] v,
                     input logic w, input logic w4, input logic t);
    ch = c; ch4 = c4; sample_in = v; rdy = w; rdy4 = w4; trig = t;
    cyc();
    rdy = 1'b0; rdy4 = 1'b0; trig = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    int ones0, ones1;
    logic [11:0] pat0, pat1;
    reset_n = 1'b0; sample_in = '0; ch = 1'b0; ch4 = '0;
    rdy = 1'b0; rdy4 = 1'b0; trig = 1'b0; sat_clr = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;

    // 1. Mid-run reset with nonzero samples, then first tick with x=0.
    put(1'b0, 2'd0, 18'h08000, 1'b1, 1'b1, 1'b0);
    put(1'b1, 2'd1, 18'h38000, 1'b1, 1'b1, 1'b1);
    repeat (50) cyc();
    #3 reset_n = 1'b0;
    #1;
    chk("rst_async_dout", 32'(dout), 32'h0);
    chk("rst_async_sat", 32'(sat_flag), 32'h0);
    chk("rst_async_dout4", 32'(dout4), 32'h0);
    repeat (3) cyc();
    chk("rst_hold_dout", 32'(dout), 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("first_tick_dout", 32'(dout), 32'h3);
    chk("first_tick_dout4", 32'(dout4), 32'h7);
    chk("post_rst_sat", 32'(sat_flag), 32'h0);

    // 2. Zero input: tick 1 seen above; trigger on tick 2 commits cleared pending.
    ones0 = dout[0]; ones1 = dout[1];
    pat0 = {11'h0, dout[0]}; pat1 = {11'h0, dout[1]};
    trig = 1'b1; cyc(); trig = 1'b0;
    for (int k = 2; k <= 1024; k++) begin
      if (k != 2) cyc();
      ones0 += dout[0]; ones1 += dout[1];
      if (k <= 12) begin
        pat0 = {pat0[10:0], dout[0]};
        pat1 = {pat1[10:0], dout[1]};
      end
    end
`ifndef SIGMA_DELTA_DITHER_EN
    // i2 after ticks 1..12: 2,1,-1,0,-2,-1,1,0,-2,-1,1,0 (x FS)
    chk("zero_pattern_ch0", 32'(pat0), 32'hD33);
    chk("zero_pattern_ch1", 32'(pat1), 32'hD33);
`endif
    chk($sformatf("zero_ones_ch0 n=%0d", ones0), 32'(ones0 >= 511 && ones0 <= 513), 32'h1);
    chk($sformatf("zero_ones_ch1 n=%0d", ones1), 32'(ones1 >= 511 && ones1 <= 513), 32'h1);

    // 3. +0.5 / -0.5; ch1 written in the trigger cycle (write-through).
    put(1'b0, 2'd0, 18'h08000, 1'b1, 1'b1, 1'b0);
    put(1'b1, 2'd1, 18'h38000, 1'b1, 1'b1, 1'b1);
    repeat (64) cyc();
    ones0 = 0; ones1 = 0;
    repeat (16384) begin cyc(); ones0 += dout[0]; ones1 += dout[1]; end
    chk($sformatf("dc_p05_ch0 n=%0d", ones0), 32'(ones0 >= 12125 && ones0 <= 12451), 32'h1);
    chk($sformatf("dc_m05_ch1 n=%0d", ones1), 32'(ones1 >= 3933 && ones1 <= 4259), 32'h1);
    chk("dc_no_sat", 32'(sat_flag), 32'h0);

    // 4. Pending write without trigger must not reach the modulator.
    put(1'b0, 2'd0, 18'h10000, 1'b1, 1'b1, 1'b0);
    ones0 = 0;
    repeat (4096) begin cyc(); ones0 += dout[0]; end
    chk($sformatf("dbuf_hold_ch0 n=%0d", ones0), 32'(ones0 >= 3031 && ones0 <= 3113), 32'h1);
    put(1'b0, 2'd0, 18'h30000, 1'b1, 1'b1, 1'b1);
    repeat (64) cyc();
    ones0 = 0; ones1 = 0;
    repeat (4096) begin cyc(); ones0 += dout[0]; ones1 += dout[1]; end
    chk($sformatf("dbuf_m10_ch0 n=%0d", ones0), 32'(ones0 <= 41), 32'h1);
    chk($sformatf("dbuf_keep_ch1 n=%0d", ones1), 32'(ones1 >= 983 && ones1 <= 1065), 32'h1);

    // 5. +1.5 clamps to +FS.
    do_reset();
    put(1'b0, 2'd0, 18'h18000, 1'b1, 1'b1, 1'b1);
    chk("clamp_before_tick", 32'(sat_flag), 32'h0);
    cyc();
    chk("clamp_after_tick", 32'(sat_flag), 32'h1);
    ones0 = 0;
    repeat (256) begin cyc(); ones0 += dout[0]; end
    chk("clamp_density", 32'(ones0), 32'd256);
    for (int k = 0; k < 8 && (ec % 4) != 1; k++) cyc();
    chk("clr_align", 32'(ec % 4), 32'd1);
    sat_clr = 1'b1; cyc(); sat_clr = 1'b0;
    chk("clr_set_wins", 32'(sat_flag), 32'h1);
    chk("clr_between_ticks4", 32'(sat_flag4), 32'h0);
    cyc(); cyc();
    chk("clr_still_clear4", 32'(sat_flag4), 32'h0);
    cyc();
    chk("clr_reset_on_tick4", 32'(sat_flag4), 32'h1);

    // 6. OSR_DIV=4: illegal index 3 ignored, output moves only on tick edges.
    do_reset();
    prev4 = dout4; mon = 1'b1;
    put(1'b0, 2'd3, 18'h18000, 1'b0, 1'b1, 1'b1);
    put(1'b0, 2'd0, 18'h04000, 1'b0, 1'b1, 1'b1);
    repeat (998) cyc();
    for (int ph = 0; ph < 4; ph++) begin
      put(1'b0, 2'd0, (ph % 2) ? 18'h04000 : 18'h3C000, 1'b0, 1'b1, 1'b1);
      repeat (999) cyc();
    end
    mon = 1'b0;
    chk("osr4_off_tick_changes", 32'(bad), 32'd0);
    chk($sformatf("osr4_activity n=%0d", changes), 32'(changes > 100), 32'h1);
    chk("osr4_illegal_ch_no_sat", 32'(sat_flag4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
